alu_sm_param: RTL
=================

# alu_sm_param

Parametrised sign-magnitude ALU, the successor of the fixed 5-bit ALU. It adds generic operand width, a valid/ready handshake on both sides and result back-pressure. It keeps the same operation sets: set A, set B1 and set B2. It sits between the operand source and the result consumer as a single-issue, multi-cycle unit.

## Interface
- WIDTH, 5: operand width. MSB is the sign; the lower WIDTH-1 bits are the magnitude. WIDTH >= 3.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_en  in  1  global enable; gates acceptance only.
- in_valid  in  1  operation request.
- in_ready  out  1  high when a request can be accepted.
- a_en, b_en  in  1 each  mode select, captured with the request.
- a_op  in  3  set A opcode.
- b_op  in  2  set B opcode.
- A, B  in  WIDTH each  sign-magnitude operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- C  out  WIDTH+1  result: C[WIDTH] is the sign, C[WIDTH-1:0] is the magnitude.
- out_err  out  1  the request carried an illegal mode (a_en=b_en=0).

## Operation
- FSM states: IDLE, EXEC, DONE.
- in_ready = alu_en && state==IDLE.
- Accept on in_valid && in_ready: register A, B, a_op, b_op, a_en, b_en, then go to EXEC.
- EXEC: compute, register C and out_err, set out_valid, go to DONE. Unconditional, one cycle.
- DONE: hold C, out_err and out_valid stable. Leave on out_valid && out_ready, then clear out_valid and return to IDLE.
- Mode: A only = set A; B only = set B1; both = set B2; neither = C=0, out_err=1.
- Set A: 0 ADD, 1 SUB, 2 XOR, 3/4 AND, 5 logical OR (C=1 if either operand nonzero, else 0), 6 XNOR, 7 gives 0.
- Set B1: 0 NAND, 1/2 ADD, 3 gives 0.
- Set B2: 0 XOR, 1 XNOR, 2 A-1, 3 B+2. Constants are positive sign-magnitude values.
- Bitwise ops act on all WIDTH bits and are zero-extended to WIDTH+1.
- ADD, same signs: magnitude = M(A)+M(B), WIDTH bits, carry kept. Sign = common sign.
- ADD, different signs: magnitude = larger magnitude − smaller magnitude. Sign = sign of the larger.
- ADD, equal magnitudes with opposite signs: +0 (all zeros). Negative zero is never produced.
- SUB = ADD with the sign of B inverted.
- Operands are used as given: −0 inputs are legal and treated as magnitude 0.
- alu_en falling during EXEC/DONE does not abort the operation.

## Timing
- Reset values: state IDLE, C=0, out_valid=0, out_err=0, operand registers 0. in_ready = alu_en.
- Accept at edge k: out_valid=1 after edge k+1.
- Minimum issue interval: 3 cycles with out_ready held high (accept, EXEC, DONE handshake).
- in_ready is low in EXEC and DONE. in_valid is ignored there; no queueing.
- Inputs may change freely after the accept edge. The result depends only on captured values.
- Reset asserted mid-operation: immediate return to the reset values. The in-flight result is discarded.

## Configuration
- ALU_FLAGS_EN defined: adds output ports out_zero (C==0) and out_ovf (1 when an ADD/SUB-family result magnitude has C[WIDTH-1]=1, i.e. it exceeded WIDTH-1 bits). Both are registered with C and held in DONE; reset value 0.
- ALU_FLAGS_EN undefined: the ports and logic are absent. All other behaviour is identical.

## Structure
- Package alu_sm_pkg holds:
  - state enum (IDLE/EXEC/DONE);
  - mode codes;
  - set A/B1/B2 opcode constants;
  - constants for +1 and +2.
- Sub-module alu_sm_addsub: combinational sign-magnitude adder/subtractor, parametrised by WIDTH, with inputs a, b, sub and output {sign, magnitude}. It is used for ADD, SUB, A-1 and B+2.
- The top level holds the FSM, the capture registers, the op mux and the output registers.

## Test plan
- WIDTH=5, set A, a_op=0, A=00011, B=00101 -> C=001000 (+8), out_valid one cycle after accept.
- Set A, a_op=1, A=00011, B=00101 -> C=100010 (−2). With A=00100, B=10100 and a_op=0 -> C=000000, no negative zero.
- Set A, a_op=0, A=01111, B=01111 -> C=011110. With ALU_FLAGS_EN: out_ovf=1, out_zero=0.
- Set B2, b_op=3, B=00111 -> C=001001. Then b_op=2, A=00000 -> C=100001 (−1).
- out_ready low for 3 cycles after a result: C and out_valid stable, in_ready=0, a second in_valid pulse is not accepted. A mode-neither request -> C=0, out_err=1.
- rst_n pulsed low during EXEC -> out_valid=0, C=0, in_ready=alu_en next cycle. The following request completes normally.

Source files
------------

// File: rtl/alu_sm_pkg.sv
// alu_sm_pkg
// Shared types and constants for the parametrised sign-magnitude ALU:
//   - state_e : controller states (IDLE / EXEC / DONE)
//   - mode_e  : operation set selected by {b_en, a_en}
//   - opcode constants for set A, set B1 and set B2
//   - magnitudes of the +1 / +2 constants used by A-1 and B+2
// Optional feature macro used elsewhere in this slice: ALU_FLAGS_EN.
package alu_sm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoded directly as {b_en, a_en} so the captured enables cast straight in.
  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_A    = 2'b01,
    MODE_B1   = 2'b10,
    MODE_B2   = 2'b11
  } mode_e;

  // Set A opcodes
  localparam logic [2:0] A_ADD  = 3'd0;
  localparam logic [2:0] A_SUB  = 3'd1;
  localparam logic [2:0] A_XOR  = 3'd2;
  localparam logic [2:0] A_AND0 = 3'd3;
  localparam logic [2:0] A_AND1 = 3'd4;
  localparam logic [2:0] A_LOR  = 3'd5;
  localparam logic [2:0] A_XNOR = 3'd6;
  localparam logic [2:0] A_ZERO = 3'd7;

  // Set B1 opcodes
  localparam logic [1:0] B1_NAND = 2'd0;
  localparam logic [1:0] B1_ADD0 = 2'd1;
  localparam logic [1:0] B1_ADD1 = 2'd2;
  localparam logic [1:0] B1_ZERO = 2'd3;

  // Set B2 opcodes
  localparam logic [1:0] B2_XOR  = 2'd0;
  localparam logic [1:0] B2_XNOR = 2'd1;
  localparam logic [1:0] B2_DEC  = 2'd2;
  localparam logic [1:0] B2_INC2 = 2'd3;

  // Positive constants; sized to WIDTH at the point of use (WIDTH >= 3
  // guarantees both fit in the magnitude field with sign bit 0).
  localparam logic [1:0] POS_ONE_MAG = 2'd1;
  localparam logic [1:0] POS_TWO_MAG = 2'd2;

endpackage

// File: rtl/alu_sm_addsub.sv
// alu_sm_addsub
// Combinational sign-magnitude adder/subtractor.
// Ports:
//   a, b : WIDTH-bit sign-magnitude operands (MSB = sign)
//   sub  : 1 = compute a - b (sign of b inverted)
//   res  : {sign, magnitude[WIDTH-1:0]}; the magnitude keeps the carry bit
// A zero magnitude always yields sign 0, so -0 is never produced even when
// both inputs are negative zero.
module alu_sm_addsub
  import alu_sm_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   res
);

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] mag;
  logic             sign;

  always_comb begin
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1] ^ sub;
    // One spare bit so a same-sign sum cannot overflow.
    mag_a  = {1'b0, a[WIDTH-2:0]};
    mag_b  = {1'b0, b[WIDTH-2:0]};
    mag    = '0;
    sign   = 1'b0;
    if (sign_a == sign_b) begin
      mag  = mag_a + mag_b;
      sign = sign_a;
    end else if (mag_a >= mag_b) begin
      mag  = mag_a - mag_b;
      sign = sign_a;
    end else begin
      mag  = mag_b - mag_a;
      sign = sign_b;
    end
    if (mag == '0) begin
      sign = 1'b0;
    end
    res = {sign, mag};
  end

endmodule

// File: rtl/alu_sm_param.sv
// alu_sm_param
// Single-issue, multi-cycle sign-magnitude ALU with valid/ready handshakes.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   alu_en                : gates request acceptance only
//   in_valid / in_ready   : request handshake
//   a_en, b_en            : mode select, captured with the request
//   a_op (3b), b_op (2b)  : set A / set B opcodes
//   A, B (WIDTH)          : sign-magnitude operands
//   out_valid / out_ready : result handshake
//   C (WIDTH+1)           : {sign, magnitude} result
//   out_err               : request had a_en = b_en = 0
//   out_zero, out_ovf     : only when ALU_FLAGS_EN is defined
// Flow: IDLE --accept--> EXEC --(1 cycle)--> DONE --out_ready--> IDLE.
module alu_sm_param
  import alu_sm_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_en,
  input  logic             b_en,
  input  logic [2:0]       a_op,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   C,
  output logic             out_err
`ifdef ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);

  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(POS_ONE_MAG);
  localparam logic [WIDTH-1:0] TWO_C = WIDTH'(POS_TWO_MAG);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       a_op_q, a_op_d;
  logic [1:0]       b_op_q, b_op_d;
  logic             a_en_q, a_en_d;
  logic             b_en_q, b_en_d;
  logic [WIDTH:0]   c_q, c_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
`ifdef ALU_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             arith;
`endif

  // Operation mux signals
  mode_e            mode;
  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic             as_sub;
  logic [WIDTH:0]   as_res;
  logic [WIDTH:0]   res;
  logic             res_err;
  logic             lor;

  alu_sm_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .res (as_res)
  );

  // Adder operand steering and result selection, from captured values only.
  always_comb begin
    mode    = mode_e'({b_en_q, a_en_q});
    as_a    = a_q;
    as_b    = b_q;
    as_sub  = 1'b0;
    res     = '0;
    res_err = 1'b0;
`ifdef ALU_FLAGS_EN
    arith   = 1'b0;
`endif
    // Logical OR looks at magnitudes so that -0 counts as zero.
    lor     = (|a_q[WIDTH-2:0]) | (|b_q[WIDTH-2:0]);
    case (mode)
      MODE_A: begin
        case (a_op_q)
          A_ADD, A_SUB: begin
            as_sub = (a_op_q == A_SUB);
            res    = as_res;
`ifdef ALU_FLAGS_EN
            arith  = 1'b1;
`endif
          end
          A_XOR:          res = {1'b0, a_q ^ b_q};
          A_AND0, A_AND1: res = {1'b0, a_q & b_q};
          A_LOR:          res = {{WIDTH{1'b0}}, lor};
          A_XNOR:         res = {1'b0, ~(a_q ^ b_q)};
          default:        res = '0;
        endcase
      end
      MODE_B1: begin
        case (b_op_q)
          B1_NAND: res = {1'b0, ~(a_q & b_q)};
          B1_ADD0, B1_ADD1: begin
            res   = as_res;
`ifdef ALU_FLAGS_EN
            arith = 1'b1;
`endif
          end
          default: res = '0;
        endcase
      end
      MODE_B2: begin
        case (b_op_q)
          B2_XOR:  res = {1'b0, a_q ^ b_q};
          B2_XNOR: res = {1'b0, ~(a_q ^ b_q)};
          B2_DEC: begin
            as_b   = ONE_C;
            as_sub = 1'b1;
            res    = as_res;
`ifdef ALU_FLAGS_EN
            arith  = 1'b1;
`endif
          end
          default: begin
            as_a  = b_q;
            as_b  = TWO_C;
            res   = as_res;
`ifdef ALU_FLAGS_EN
            arith = 1'b1;
`endif
          end
        endcase
      end
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  assign in_ready = alu_en && (state_q == ST_IDLE);

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_op_d  = a_op_q;
    b_op_d  = b_op_q;
    a_en_d  = a_en_q;
    b_en_d  = b_en_q;
    c_d     = c_q;
    err_d   = err_q;
    valid_d = valid_q;
`ifdef ALU_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && alu_en) begin
          a_d     = A;
          b_d     = B;
          a_op_d  = a_op;
          b_op_d  = b_op;
          a_en_d  = a_en;
          b_en_d  = b_en;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        c_d     = res;
        err_d   = res_err;
        valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
        zero_d  = (res == '0);
        ovf_d   = arith && res[WIDTH-1];
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_op_q  <= '0;
      b_op_q  <= '0;
      a_en_q  <= 1'b0;
      b_en_q  <= 1'b0;
      c_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      a_en_q  <= a_en_d;
      b_en_q  <= b_en_d;
      c_q     <= c_d;
      err_q   <= err_d;
      valid_q <= valid_d;
`ifdef ALU_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign C         = c_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;
`ifdef ALU_FLAGS_EN
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
`endif

endmodule
